// File: rtl/gelato_compute_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : gelato_compute_dispatcher
// Brief    : Warp instruction front end for the SIMT ALU lanes. Decodes
//            R-type / I-type arithmetic into a lane task, waits for the
//            lanes, then offers the per-thread result for writeback.
// Options  : GELATO_CU_TIMEOUT_EN - EXEC watchdog of TIMEOUT cycles
// Revision : 1.0 - initial release
// ============================================================================
module gelato_compute_dispatcher #(
  parameter int THREAD_NUM = 32,
  parameter int DATA_W     = 32,
  parameter int WARP_NUM_W = 5,
  parameter int REG_NUM_W  = 5,
  parameter int PC_W       = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [6:0]                   in_opcode,
  input  logic [2:0]                   in_funct3,
  input  logic [6:0]                   in_funct7,
  input  logic [DATA_W-1:0]            in_imm,
  input  logic [THREAD_NUM*DATA_W-1:0] in_src1,
  input  logic [THREAD_NUM*DATA_W-1:0] in_src2,
  input  logic [REG_NUM_W-1:0]         in_rd,
  input  logic [WARP_NUM_W-1:0]        in_warp,
  input  logic [THREAD_NUM-1:0]        in_mask,
  input  logic [PC_W-1:0]              in_pc,
  output logic                         task_valid,
  output logic [3:0]                   task_op,
  output logic [THREAD_NUM*DATA_W-1:0] task_rs1,
  output logic [THREAD_NUM*DATA_W-1:0] task_rs2,
  input  logic                         task_done,
  input  logic [THREAD_NUM*DATA_W-1:0] task_rd,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic [THREAD_NUM*DATA_W-1:0] wb_data,
  output logic [WARP_NUM_W-1:0]        wb_warp,
  output logic [REG_NUM_W-1:0]         wb_reg,
  output logic [THREAD_NUM-1:0]        wb_mask,
  output logic                         err_illegal,
  output logic [PC_W-1:0]              err_pc,
  output logic [31:0]                  retired
);

  localparam logic [6:0] c_OPC_ARITHI = 7'b0010011;
  localparam logic [6:0] c_OPC_ARITH  = 7'b0110011;
  localparam logic [6:0] c_F7_ALT     = 7'b0100000;

  // Lane compute op encoding
  localparam logic [3:0] c_OP_ADD = 4'd0;
  localparam logic [3:0] c_OP_SUB = 4'd1;
  localparam logic [3:0] c_OP_XOR = 4'd2;
  localparam logic [3:0] c_OP_OR  = 4'd3;
  localparam logic [3:0] c_OP_AND = 4'd4;
  localparam logic [3:0] c_OP_SLT = 4'd5;
  localparam logic [3:0] c_OP_SLL = 4'd6;
  localparam logic [3:0] c_OP_SRL = 4'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic                           w_accept;
  logic                           w_retire;
  logic                           w_tmo_hit;
  logic                           w_f3_ok;
  logic [3:0]                     w_f3_op;
  logic                           w_dec_legal;
  logic [3:0]                     w_dec_op;
  logic [3:0]                     r_op;
  logic [THREAD_NUM*DATA_W-1:0]   r_rs1;
  logic [THREAD_NUM*DATA_W-1:0]   r_rs2;
  logic [THREAD_NUM*DATA_W-1:0]   r_wb_data;
  logic [WARP_NUM_W-1:0]          r_wb_warp;
  logic [REG_NUM_W-1:0]           r_wb_reg;
  logic [THREAD_NUM-1:0]          r_wb_mask;
  logic [PC_W-1:0]                r_pc;
  logic                           r_err;
  logic [PC_W-1:0]                r_err_pc;
  logic [31:0]                    r_retired;

  assign w_accept   = in_valid && (r_state == S_IDLE);
  assign in_ready   = (r_state == S_IDLE);
  assign task_valid = (r_state == S_EXEC);
  assign wb_valid   = (r_state == S_WB);
  assign task_op    = r_op;
  assign task_rs1   = r_rs1;
  assign task_rs2   = r_rs2;
  assign wb_data    = r_wb_data;
  assign wb_warp    = r_wb_warp;
  assign wb_reg     = r_wb_reg;
  assign wb_mask    = r_wb_mask;
  assign err_illegal = r_err;
  assign err_pc     = r_err_pc;
  assign retired    = r_retired;

  // Decode the offered instruction into a lane op and a legality flag
  always_comb begin
    w_f3_ok     = 1'b1;
    w_f3_op     = c_OP_ADD;
    w_dec_legal = 1'b0;
    w_dec_op    = c_OP_ADD;
    case (in_funct3)
      3'b000:  w_f3_op = c_OP_ADD;
      3'b100:  w_f3_op = c_OP_XOR;
      3'b110:  w_f3_op = c_OP_OR;
      3'b111:  w_f3_op = c_OP_AND;
      3'b010:  w_f3_op = c_OP_SLT;
      3'b001:  w_f3_op = c_OP_SLL;
      3'b101:  w_f3_op = c_OP_SRL;
      default: w_f3_ok = 1'b0;
    endcase
    if (in_opcode == c_OPC_ARITHI) begin
      w_dec_legal = w_f3_ok;
      w_dec_op    = w_f3_op;
    end else if (in_opcode == c_OPC_ARITH) begin
      if (in_funct7 == 7'd0) begin
        w_dec_legal = w_f3_ok;
        w_dec_op    = w_f3_op;
      end else if ((in_funct7 == c_F7_ALT) && (in_funct3 == 3'b000)) begin
        w_dec_legal = 1'b1;
        w_dec_op    = c_OP_SUB;
      end
    end
  end

`ifdef GELATO_CU_TIMEOUT_EN
  localparam int c_TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [c_TMO_W-1:0] r_tmo_cnt;

  // Count cycles spent in EXEC; restarts whenever EXEC is left
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_tmo_cnt <= '0;
    else if (r_state != S_EXEC)  r_tmo_cnt <= '0;
    else                         r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  // A task_done on the expiry cycle takes priority over the watchdog
  assign w_tmo_hit = (r_state == S_EXEC) && !task_done &&
                     (r_tmo_cnt == c_TMO_W'(TIMEOUT - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and retire decision
  always_comb begin
    w_state_nxt = r_state;
    w_retire    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_dec_legal) w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (task_done) begin
          // Nothing to write back: retire directly from EXEC
          if ((r_wb_reg == '0) || (r_wb_mask == '0)) begin
            w_state_nxt = S_IDLE;
            w_retire    = 1'b1;
          end else begin
            w_state_nxt = S_WB;
          end
        end else if (w_tmo_hit) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WB: begin
        if (wb_ready) begin
          w_state_nxt = S_IDLE;
          w_retire    = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Instruction capture, lane result capture, error reporting, retire count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= c_OP_ADD;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_wb_data <= '0;
      r_wb_warp <= '0;
      r_wb_reg  <= '0;
      r_wb_mask <= '0;
      r_pc      <= '0;
      r_err     <= 1'b0;
      r_err_pc  <= '0;
      r_retired <= '0;
    end else begin
      r_err <= 1'b0;
      if (w_accept) begin
        if (w_dec_legal) begin
          r_op      <= w_dec_op;
          r_rs1     <= in_src1;
          r_rs2     <= (in_opcode == c_OPC_ARITHI) ? {THREAD_NUM{in_imm}} : in_src2;
          r_wb_reg  <= in_rd;
          r_wb_warp <= in_warp;
          r_wb_mask <= in_mask;
          r_pc      <= in_pc;
        end else begin
          r_err    <= 1'b1;
          r_err_pc <= in_pc;
        end
      end
      if ((r_state == S_EXEC) && task_done) r_wb_data <= task_rd;
      if (w_tmo_hit) begin
        r_err    <= 1'b1;
        r_err_pc <= r_pc;
      end
      if (w_retire) r_retired <= r_retired + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gelato_compute_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_gelato_compute_dispatcher
// Brief    : Self-checking bench for gelato_compute_dispatcher. The bench
//            acts as issue stage, ALU lanes and register file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gelato_compute_dispatcher;

  localparam int TN    = 32;
  localparam int DW    = 32;
  localparam int VEC_W = TN * DW;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_R = 7'b0110011;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [6:0]       in_opcode = '0;
  logic [2:0]       in_funct3 = '0;
  logic [6:0]       in_funct7 = '0;
  logic [DW-1:0]    in_imm = '0;
  logic [VEC_W-1:0] in_src1 = '0;
  logic [VEC_W-1:0] in_src2 = '0;
  logic [4:0]       in_rd = '0;
  logic [4:0]       in_warp = '0;
  logic [TN-1:0]    in_mask = '0;
  logic [31:0]      in_pc = '0;
  logic             task_valid;
  logic [3:0]       task_op;
  logic [VEC_W-1:0] task_rs1;
  logic [VEC_W-1:0] task_rs2;
  logic             task_done = 1'b0;
  logic [VEC_W-1:0] task_rd = '0;
  logic             wb_valid;
  logic             wb_ready = 1'b0;
  logic [VEC_W-1:0] wb_data;
  logic [4:0]       wb_warp;
  logic [4:0]       wb_reg;
  logic [TN-1:0]    wb_mask;
  logic             err_illegal;
  logic [31:0]      err_pc;
  logic [31:0]      retired;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_retired = 0;

  gelato_compute_dispatcher #(
    .THREAD_NUM(TN), .DATA_W(DW), .WARP_NUM_W(5), .REG_NUM_W(5), .PC_W(32), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_imm(in_imm), .in_src1(in_src1), .in_src2(in_src2),
    .in_rd(in_rd), .in_warp(in_warp), .in_mask(in_mask), .in_pc(in_pc),
    .task_valid(task_valid), .task_op(task_op), .task_rs1(task_rs1), .task_rs2(task_rs2),
    .task_done(task_done), .task_rd(task_rd),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_warp(wb_warp), .wb_reg(wb_reg), .wb_mask(wb_mask),
    .err_illegal(err_illegal), .err_pc(err_pc), .retired(retired)
  );

  always #5 clk = ~clk;

  // Reference: lane op implied by an encoding, -1 when illegal
  function automatic int ref_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
    int base;
    case (f3)
      3'b000: base = 0;  // ADD
      3'b001: base = 6;  // SLL
      3'b010: base = 5;  // SLT
      3'b100: base = 2;  // XOR
      3'b101: base = 7;  // SRL
      3'b110: base = 3;  // OR
      3'b111: base = 4;  // AND
      default: base = -1;
    endcase
    if (opc == OPC_I) return base;
    if (opc != OPC_R) return -1;
    if (f7 == 7'd0) return base;
    if (f7 == 7'b0100000 && f3 == 3'b000) return 1;  // SUB
    return -1;
  endfunction

  // Reference: what a correct SIMT lane array would return
  function automatic logic [VEC_W-1:0] lane_calc(input int op, input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b);
    logic [VEC_W-1:0] r;
    r = '0;
    for (int t = 0; t < TN; t++) begin
      logic [31:0] x, y, z;
      x = a[t*DW +: DW];
      y = b[t*DW +: DW];
      case (op)
        0: z = x + y;
        1: z = x - y;
        2: z = x ^ y;
        3: z = x | y;
        4: z = x & y;
        5: z = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        6: z = x << y[4:0];
        default: z = x >> y[4:0];
      endcase
      r[t*DW +: DW] = z;
    end
    return r;
  endfunction

  function automatic logic [VEC_W-1:0] rand_vec();
    logic [VEC_W-1:0] v;
    for (int t = 0; t < TN; t++) v[t*DW +: DW] = $urandom;
    return v;
  endfunction

  function automatic logic [VEC_W-1:0] fill_vec(input logic [31:0] val);
    return {TN{val}};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; task_done = 1'b0; wb_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_retired = 0;
    @(posedge clk); #1;
  endtask

  // Issue one instruction and play lanes/regfile. rst_in_wb resets while in WB.
  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] imm, input logic [VEC_W-1:0] s1, input logic [VEC_W-1:0] s2,
                           input logic [4:0] rd, input logic [4:0] warp, input logic [31:0] mask,
                           input logic [31:0] pc, input int done_dly, input int wb_dly,
                           input bit rst_in_wb, input string tag);
    int op;
    logic [VEC_W-1:0] exp_rs2, lane;
    op = ref_op(opc, f3, f7);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s pre_ready: got %b want 1", tag, in_ready); end
    in_valid = 1'b1; in_opcode = opc; in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    in_src1 = s1; in_src2 = s2; in_rd = rd; in_warp = warp; in_mask = mask; in_pc = pc;
    @(posedge clk); #1;
    // Scramble the issue bus: the dispatcher must not look at it again
    in_valid = 1'b0; in_opcode = 7'($urandom); in_funct3 = 3'($urandom); in_funct7 = 7'($urandom);
    in_imm = $urandom; in_src1 = rand_vec(); in_src2 = rand_vec(); in_rd = 5'($urandom);
    in_warp = 5'($urandom); in_mask = $urandom; in_pc = $urandom;
    if (op < 0) begin
      checks++;
      if (err_illegal !== 1'b1 || err_pc !== pc) begin
        errors++; $display("FAIL %s illegal_err: got err=%b pc=%h want err=1 pc=%h", tag, err_illegal, err_pc, pc);
      end
      checks++;
      if (task_valid !== 1'b0 || in_ready !== 1'b1 || retired !== exp_retired) begin
        errors++; $display("FAIL %s illegal_state: got tv=%b rdy=%b ret=%0d want tv=0 rdy=1 ret=%0d", tag, task_valid, in_ready, retired, exp_retired);
      end
      @(posedge clk); #1;
      checks++;
      if (err_illegal !== 1'b0 || task_valid !== 1'b0) begin
        errors++; $display("FAIL %s illegal_pulse: got err=%b tv=%b want 0 0", tag, err_illegal, task_valid);
      end
      return;
    end
    exp_rs2 = (opc == OPC_I) ? fill_vec(imm) : s2;
    lane = lane_calc(op, s1, exp_rs2);
    checks++;
    if (task_valid !== 1'b1 || in_ready !== 1'b0 || task_op !== 4'(op)) begin
      errors++; $display("FAIL %s task_issue: got tv=%b rdy=%b op=%0d want tv=1 rdy=0 op=%0d", tag, task_valid, in_ready, task_op, op);
    end
    checks++;
    if (task_rs1 !== s1 || task_rs2 !== exp_rs2) begin
      errors++; $display("FAIL %s task_operands: got rs1[0]=%h rs2[0]=%h want %h %h", tag, task_rs1[31:0], task_rs2[31:0], s1[31:0], exp_rs2[31:0]);
    end
    for (int i = 0; i < done_dly; i++) begin
      @(posedge clk); #1;
      checks++;
      if (task_valid !== 1'b1 || task_op !== 4'(op) || task_rs1 !== s1 || task_rs2 !== exp_rs2) begin
        errors++; $display("FAIL %s task_hold: got tv=%b op=%0d want tv=1 op=%0d", tag, task_valid, task_op, op);
      end
    end
    task_done = 1'b1; task_rd = lane;
    @(posedge clk); #1;
    task_done = 1'b0; task_rd = rand_vec();
    checks++;
    if (task_valid !== 1'b0) begin errors++; $display("FAIL %s task_drop: got tv=%b want 0", tag, task_valid); end
    if (rd == 5'd0 || mask == 32'd0) begin
      exp_retired++;
      checks++;
      if (wb_valid !== 1'b0 || in_ready !== 1'b1 || retired !== exp_retired) begin
        errors++; $display("FAIL %s skip_wb: got wbv=%b rdy=%b ret=%0d want 0 1 %0d", tag, wb_valid, in_ready, retired, exp_retired);
      end
      return;
    end
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== lane || wb_reg !== rd || wb_warp !== warp || wb_mask !== mask) begin
      errors++; $display("FAIL %s wb_offer: got v=%b d0=%h reg=%0d warp=%0d mask=%h want 1 %h %0d %0d %h",
                         tag, wb_valid, wb_data[31:0], wb_reg, wb_warp, wb_mask, lane[31:0], rd, warp, mask);
    end
    for (int i = 0; i < wb_dly; i++) begin
      @(posedge clk); #1;
      checks++;
      if (wb_valid !== 1'b1 || in_ready !== 1'b0 || wb_data !== lane || wb_reg !== rd || wb_mask !== mask) begin
        errors++; $display("FAIL %s wb_hold: got v=%b rdy=%b reg=%0d want 1 0 %0d", tag, wb_valid, in_ready, wb_reg, rd);
      end
    end
    if (rst_in_wb) begin
      rst_n = 1'b0;
      #1;
      exp_retired = 0;
      checks++;
      if (wb_valid !== 1'b0 || in_ready !== 1'b1 || wb_data !== '0 || wb_reg !== 5'd0 || retired !== 32'd0) begin
        errors++; $display("FAIL %s rst_in_wb: got v=%b rdy=%b reg=%0d ret=%0d want 0 1 0 0", tag, wb_valid, in_ready, wb_reg, retired);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      return;
    end
    wb_ready = 1'b1;
    @(posedge clk); #1;
    wb_ready = 1'b0;
    exp_retired++;
    checks++;
    if (wb_valid !== 1'b0 || in_ready !== 1'b1 || retired !== exp_retired) begin
      errors++; $display("FAIL %s wb_done: got v=%b rdy=%b ret=%0d want 0 1 %0d", tag, wb_valid, in_ready, retired, exp_retired);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (in_ready !== 1'b1 || task_valid !== 1'b0 || wb_valid !== 1'b0 || err_illegal !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got rdy=%b tv=%b wbv=%b err=%b want 1 0 0 0", in_ready, task_valid, wb_valid, err_illegal);
    end
    checks++;
    if (task_rs1 !== '0 || task_rs2 !== '0 || wb_data !== '0 || wb_reg !== 5'd0 || wb_warp !== 5'd0 ||
        wb_mask !== '0 || err_pc !== 32'd0 || retired !== 32'd0) begin
      errors++; $display("FAIL reset_data: got wbreg=%0d mask=%h errpc=%h ret=%0d want all 0", wb_reg, wb_mask, err_pc, retired);
    end
  endtask

  task automatic test_addi();
    run_instr(OPC_I, 3'b000, 7'd0, 32'd5, fill_vec(32'd10), rand_vec(), 5'd3, 5'd1, 32'hFFFFFFFF,
              32'h100, 2, 0, 1'b0, "addi");
    checks++;
    if (wb_data !== fill_vec(32'd15) || retired !== 32'd1) begin
      errors++; $display("FAIL addi_result: got d0=%h ret=%0d want 0000000f 1", wb_data[31:0], retired);
    end
  endtask

  task automatic test_sub_hold();
    run_instr(OPC_R, 3'b000, 7'b0100000, 32'd0, rand_vec(), rand_vec(), 5'd7, 5'd2, $urandom | 32'h1,
              32'h104, 1, 4, 1'b0, "sub_hold");
  endtask

  task automatic test_illegal();
    run_instr(7'b1111111, 3'b000, 7'd0, 32'd0, rand_vec(), rand_vec(), 5'd4, 5'd0, 32'hF,
              32'h40, 0, 0, 1'b0, "illegal_opc");
    run_instr(OPC_R, 3'b001, 7'b0100000, 32'd0, rand_vec(), rand_vec(), 5'd4, 5'd0, 32'hF,
              32'h44, 0, 0, 1'b0, "illegal_f7");
    run_instr(OPC_I, 3'b011, 7'd0, 32'd0, rand_vec(), rand_vec(), 5'd4, 5'd0, 32'hF,
              32'h48, 0, 0, 1'b0, "illegal_f3");
  endtask

  task automatic test_rd_zero();
    run_instr(OPC_I, 3'b000, 7'd0, 32'd9, rand_vec(), rand_vec(), 5'd0, 5'd3, 32'hFFFF,
              32'h200, 1, 0, 1'b0, "rd_zero");
    run_instr(OPC_R, 3'b110, 7'd0, 32'd0, rand_vec(), rand_vec(), 5'd8, 5'd3, 32'h0,
              32'h204, 0, 0, 1'b0, "mask_zero");
  endtask

  task automatic test_stray_handshakes();
    task_done = 1'b1; wb_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    task_done = 1'b0; wb_ready = 1'b0;
    checks++;
    if (task_valid !== 1'b0 || wb_valid !== 1'b0 || in_ready !== 1'b1 || retired !== exp_retired) begin
      errors++; $display("FAIL stray: got tv=%b wbv=%b rdy=%b ret=%0d want 0 0 1 %0d", task_valid, wb_valid, in_ready, retired, exp_retired);
    end
  endtask

  task automatic test_reset_in_wb();
    run_instr(OPC_R, 3'b100, 7'd0, 32'd0, rand_vec(), rand_vec(), 5'd12, 5'd4, 32'hA5A5A5A5,
              32'h300, 0, 2, 1'b1, "rst_wb");
    run_instr(OPC_I, 3'b111, 7'd0, 32'h0000FF00, rand_vec(), rand_vec(), 5'd13, 5'd5, 32'h1,
              32'h304, 0, 0, 1'b0, "after_rst");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++)
      run_instr(OPC_R, 3'b000, 7'd0, 32'd0, rand_vec(), rand_vec(), 5'(i + 1), 5'(i), 32'hFFFFFFFF,
                32'h400 + 32'(i * 4), 0, 0, 1'b0, "b2b");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [6:0] opc;
      logic [6:0] f7;
      int sel;
      sel = $urandom_range(0, 9);
      opc = (sel < 5) ? OPC_I : (sel < 9) ? OPC_R : 7'($urandom);
      sel = $urandom_range(0, 9);
      f7 = (sel < 7) ? 7'd0 : (sel < 9) ? 7'b0100000 : 7'($urandom);
      run_instr(opc, 3'($urandom), f7, $urandom, rand_vec(), rand_vec(),
                ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                5'($urandom), ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
                $urandom, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, "random");
    end
  endtask

`ifdef GELATO_CU_TIMEOUT_EN
  task automatic test_timeout();
    in_valid = 1'b1; in_opcode = OPC_I; in_funct3 = 3'b000; in_funct7 = 7'd0; in_imm = 32'd1;
    in_src1 = rand_vec(); in_rd = 5'd6; in_mask = 32'hF; in_pc = 32'h500;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (task_valid !== 1'b1) begin errors++; $display("FAIL timeout_hold: cycle %0d got tv=%b want 1", i, task_valid); end
      @(posedge clk); #1;
    end
    checks++;
    if (task_valid !== 1'b0 || err_illegal !== 1'b1 || err_pc !== 32'h500 || in_ready !== 1'b1 ||
        wb_valid !== 1'b0 || retired !== exp_retired) begin
      errors++; $display("FAIL timeout_fire: got tv=%b err=%b pc=%h rdy=%b ret=%0d want 0 1 00000500 1 %0d",
                         task_valid, err_illegal, err_pc, in_ready, retired, exp_retired);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_addi();
    test_sub_hold();
    test_illegal();
    test_rd_zero();
    test_stray_handshakes();
    test_back_to_back();
    test_reset_in_wb();
    test_random();
`ifdef GELATO_CU_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/gelato_compute_dispatcher.md
# gelato_compute_dispatcher

Parametrised compute-unit front end for the Gelato GPU. It accepts one decoded warp instruction at a time over a valid/ready handshake and decodes R-type and I-type arithmetic into a compute-lane task. It waits for the lane to finish, then returns the per-thread result to the register file over a valid/ready writeback port. It sits between the warp issue stage and the SIMT ALU lanes. Illegal encodings raise a non-fatal error; they do not halt simulation.

## Interface
Parameters:
- THREAD_NUM, 32, threads per warp (lanes per task)
- DATA_W, 32, bits per thread operand
- WARP_NUM_W, 5, warp index width
- REG_NUM_W, 5, register index width
- PC_W, 32, program counter width
- TIMEOUT, 256, watchdog limit in cycles (used only with the timeout feature)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  instruction offered
- in_ready  out  1  dispatcher can accept
- in_opcode  in  7  opcode
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7
- in_imm  in  DATA_W  immediate, already sign-extended
- in_src1, in_src2  in  THREAD_NUM*DATA_W  per-thread operands
- in_rd  in  REG_NUM_W  destination register
- in_warp  in  WARP_NUM_W  warp number
- in_mask  in  THREAD_NUM  active-thread mask
- in_pc  in  PC_W  instruction pc
- task_valid  out  1  task presented to the lanes
- task_op  out  4  gelato_types compute op
- task_rs1, task_rs2  out  THREAD_NUM*DATA_W  lane operands
- task_done  in  1  lanes finished
- task_rd  in  THREAD_NUM*DATA_W  lane result
- wb_valid  out  1  writeback offered
- wb_ready  in  1  register file accepts
- wb_data  out  THREAD_NUM*DATA_W  writeback data
- wb_warp  out  WARP_NUM_W  writeback warp
- wb_reg  out  REG_NUM_W  writeback register
- wb_mask  out  THREAD_NUM  writeback mask
- err_illegal  out  1  one-cycle pulse on an illegal instruction
- err_pc  out  PC_W  pc of the last error
- retired  out  32  count of completed instructions, wraps

## Operation
- States: IDLE, EXEC, WB.
- in_ready = (state == IDLE).
- Accept is in_valid & in_ready. On accept, all in_* fields are registered; the dispatcher never samples in_* later.
- Decode for ARITHI (7'b0010011):
  - rs1 = src1; rs2 = in_imm replicated THREAD_NUM times.
  - funct3 000 ADD, 100 XOR, 110 OR, 111 AND, 010 SLT, 001 SLL, 101 SRL.
- Decode for ARITH (7'b0110011):
  - rs1 = src1; rs2 = src2; funct3 as above.
  - funct3 000 with funct7 0100000 is SUB.
  - Any other nonzero funct7 is illegal.
- Illegal instruction (any other opcode or funct combination):
  - Pulse err_illegal, load err_pc, do not increment retired.
  - Stay in IDLE; no task, no writeback.
- Legal instruction: go to EXEC. task_valid is held high, with task_op, task_rs1 and task_rs2 stable, until task_done is sampled high.
- On task_done, capture task_rd into wb_data and clear task_valid.
  - If rd == 0 or mask == 0: skip WB, increment retired, go to IDLE.
  - Otherwise go to WB.
- WB: hold wb_valid and the wb_* fields stable until wb_ready. Then increment retired and go to IDLE.
- The retired counter wraps from 0xFFFFFFFF to 0.
- Reset values: state IDLE; task_valid, wb_valid and err_illegal 0; all data, index, mask and pc outputs 0; retired 0.
- Reset mid-operation abandons the task and any pending writeback immediately. Outputs return to their reset values.

## Timing
- Accept at cycle 0 gives task_valid = 1 at cycle 1.
- task_done at cycle k gives wb_valid = 1 at cycle k+1, with task_valid = 0 at cycle k+1.
- wb_ready sampled at cycle j gives wb_valid = 0 and in_ready = 1 at cycle j+1.
- Minimum accept-to-accept interval: 3 cycles when task_done and wb_ready are both high immediately.
- task_done outside EXEC is ignored.
- wb_ready outside WB is ignored.
- An illegal instruction accepted at cycle 0 gives an err_illegal pulse at cycle 1, with in_ready still 1.

## Configuration
- GELATO_CU_TIMEOUT_EN defined:
  - A counter runs in EXEC. If TIMEOUT cycles elapse without task_done, the dispatcher drops task_valid, pulses err_illegal, loads err_pc and returns to IDLE without writeback or retire.
  - A task_done arriving on the same cycle the counter expires wins; the instruction completes normally.
- Undefined: the counter is not built and EXEC waits indefinitely.

## Test plan
- ADDI, opcode 0010011, funct3 000, imm 5, src1 all 10, rd 3, mask 0xFFFFFFFF, task_done after 2 cycles, lane returns all 15 -> task_op ADD, task_rs2 all 5, wb_data all 15, wb_reg 3, retired 1.
- SUB, opcode 0110011, funct7 0100000 -> task_op SUB. Hold wb_ready low for 4 cycles -> wb_* stable for 4 cycles, in_ready low throughout.
- Opcode 1111111 at pc 0x40 -> err_illegal pulse, err_pc 0x40, task_valid never 1, retired unchanged.
- rd 0 with a legal ADDI -> task issued, no wb_valid, retired increments.
- rst_n low during WB -> wb_valid 0 and state IDLE in the same cycle. After release, the next instruction completes normally.
- With GELATO_CU_TIMEOUT_EN and TIMEOUT 8, task_done never asserted -> task_valid drops after 8 cycles, err_illegal pulses, in_ready returns to 1.
